fifo_ring: RTL and testbench
============================

FIFO_RING -- requirements
Module: fifo_ring

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bit width (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, entry count (power of two, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost-empty threshold (0..DEPTH-1).
REQ-005 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port clr_i  in  1  synchronous flush, active-high.
REQ-008 SHALL have port push_i  in  1  write request.
REQ-009 SHALL have port data_i  in  WIDTH  write data.
REQ-010 SHALL have port pop_i  in  1  read request.
REQ-011 SHALL have port data_o  out  WIDTH  head entry (first-word-fall-through).
REQ-012 SHALL have port full_o  out  1  count == DEPTH.
REQ-013 SHALL have port pnding_o  out  1  count != 0 (data pending).
REQ-014 SHALL have port almost_full_o  out  1  count >= AF_LEVEL.
REQ-015 SHALL have port almost_empty_o  out  1  count <= AE_LEVEL.
REQ-016 SHALL have port count_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port overflow_o  out  1  one-cycle pulse: push rejected.
REQ-018 SHALL have port underflow_o  out  1  one-cycle pulse: pop rejected.

Function
REQ-019 SHALL store entries in a circular buffer with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 by natural overflow.
REQ-020 SHALL accept a push when push_i=1 and (full_o=0 or pop accepted same cycle): mem[wr_ptr]<=data_i, wr_ptr+1.
REQ-021 SHALL accept a pop when pop_i=1 and pnding_o=1: rd_ptr+1; no bypass from data_i when empty.
REQ-022 SHALL present mem[rd_ptr] on data_o combinationally; data_o is don't-care while pnding_o=0.
REQ-023 SHALL update count_o: +1 push only, -1 pop only, unchanged on both or neither accepted.
REQ-024 SHALL derive full_o, pnding_o, almost_full_o, almost_empty_o combinationally from count_o; zero-cycle latency from count.
REQ-025 SHALL assert overflow_o for exactly the cycle after a rejected push (push_i=1, full, no pop accepted).
REQ-026 SHALL assert underflow_o for exactly the cycle after a rejected pop (pop_i=1, empty), including push+pop on empty (push accepted, pop rejected).
REQ-027 SHALL, on clr_i=1, zero pointers, count and pulse flags at the next edge, ignoring push_i/pop_i that cycle.
REQ-028 SHALL leave memory contents unmodified by rejected pushes.

Reset
REQ-029 SHALL, on rst_i=0, immediately clear wr_ptr, rd_ptr, count_o, overflow_o, underflow_o, regardless of clock.
REQ-030 SHALL, during and after reset, drive full_o=0, pnding_o=0, almost_full_o=0, almost_empty_o=1, count_o=0.
REQ-031 SHALL not reset storage array; reset mid-operation discards all entries.

Structure
REQ-032 SHALL take shared constants (default WIDTH/DEPTH) from package fifo_pkg, reused by existing FIFO blocks.
REQ-033 SHALL instantiate one sub-module fifo_ring_mem (DEPTH x WIDTH array, sync write, async read); pointer/count logic in top.
REQ-034 SHALL include elaboration-time checks: DEPTH power of two, thresholds in range.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-035 SHALL cover: push 0x11,0x22,0x33,0x44 -> count 4, full_o=1, almost_full_o=1 from 3rd push; pops return 0x11..0x44 in order.
REQ-036 SHALL cover: full, push 0x55 without pop -> overflow_o one cycle, count stays 4, subsequent pops exclude 0x55.
REQ-037 SHALL cover: full, push 0x55 with pop -> data_o 0x11 consumed, count stays 4, last pop returns 0x55.
REQ-038 SHALL cover: empty, push 0xAA with pop -> underflow_o one cycle, count 1, data_o=0xAA.
REQ-039 SHALL cover: 10 push/pop pairs after 2 preloads -> pointers wrap, order preserved, count constant 2.
REQ-040 SHALL cover: 3 entries, rst_i low mid-cycle -> count_o=0, pnding_o=0 without clock edge; clr_i with 3 entries -> same at next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers, reused across the FIFO blocks.
//   FIFO_WIDTH   : default data width
//   FIFO_DEPTH   : default entry count
//   fifo_is_pow2 : elaboration-time power-of-two test
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 32;
  localparam int unsigned FIFO_DEPTH = 8;

  function automatic bit fifo_is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ring_mem.sv
// Storage array for fifo_ring: DEPTH x WIDTH, synchronous write, asynchronous read.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module fifo_ring_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fifo_ring.sv
// Single-clock first-word-fall-through ring FIFO with occupancy flags.
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous active-low reset
//   clr_i          : synchronous flush
//   push_i/data_i  : write request and data
//   pop_i          : read request
//   data_o         : head entry (valid while pnding_o)
//   full_o, pnding_o, almost_full_o, almost_empty_o : flags decoded from count_o
//   count_o        : occupancy
//   overflow_o     : one-cycle pulse after a rejected push
//   underflow_o    : one-cycle pulse after a rejected pop
module fifo_ring
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = FIFO_WIDTH,
  parameter int unsigned DEPTH    = FIFO_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   pnding_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Parameter sanity checks at elaboration.
  if (!fifo_is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("fifo_ring: DEPTH must be a power of two >= 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_ring: WIDTH must be >= 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_ring: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_ring: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_full;
  logic          w_pnding;
  logic          w_push_acc;
  logic          w_pop_acc;
  logic          w_mem_we;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_pnding = (r_count != '0);

  // A pop frees a slot in the same cycle, so a push on full is taken if a pop is.
  assign w_pop_acc  = pop_i & w_pnding;
  assign w_push_acc = push_i & (~w_full | w_pop_acc);
  assign w_mem_we   = w_push_acc & ~clr_i;

  fifo_ring_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_mem_we),
    .waddr_i (r_wr_ptr),
    .wdata_i (data_i),
    .raddr_i (r_rd_ptr),
    .rdata_o (data_o)
  );

  // Pointer, occupancy and pulse-flag state; pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= push_i & ~w_push_acc;
      r_underflow <= pop_i & ~w_pop_acc;
    end
  end

  assign count_o        = r_count;
  assign full_o         = w_full;
  assign pnding_o       = w_pnding;
  assign almost_full_o  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty_o = (r_count <= CW'(AE_LEVEL));
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_fifo_ring.sv
// Directed self-checking bench for fifo_ring (WIDTH=8, DEPTH=4, AF=3, AE=1).
module tb_fifo_ring;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clr_i;
  logic       push_i;
  logic [7:0] data_i;
  logic       pop_i;
  logic [7:0] data_o;
  logic       full_o;
  logic       pnding_o;
  logic       almost_full_o;
  logic       almost_empty_o;
  logic [2:0] count_o;
  logic       overflow_o;
  logic       underflow_o;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_ring #(
    .WIDTH    (8),
    .DEPTH    (4),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (clr_i),
    .push_i         (push_i),
    .data_i         (data_i),
    .pop_i          (pop_i),
    .data_o         (data_o),
    .full_o         (full_o),
    .pnding_o       (pnding_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Count plus the four flags the count implies for DEPTH=4, AF=3, AE=1.
  task automatic check_state(input string tag, input int cnt, input logic af, input logic ae);
    check_eq({tag, ".cnt"},  32'(count_o),        32'(cnt));
    check_eq({tag, ".full"}, 32'(full_o),         32'(cnt == 4));
    check_eq({tag, ".pnd"},  32'(pnding_o),       32'(cnt != 0));
    check_eq({tag, ".af"},   32'(almost_full_o),  32'(af));
    check_eq({tag, ".ae"},   32'(almost_empty_o), 32'(ae));
  endtask

  task automatic cyc(input logic push, input logic [7:0] d, input logic pop);
    push_i = push;
    data_i = d;
    pop_i  = pop;
    @(posedge clk_i);
    #1;
    push_i = 1'b0;
    pop_i  = 1'b0;
  endtask

  task automatic fill4();
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    cyc(1'b1, 8'h44, 1'b0);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check_eq({tag, ".head"}, 32'(data_o), 32'(exp));
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  logic [7:0] q[$];

  initial begin
    rst_i  = 1'b0;
    clr_i  = 1'b0;
    push_i = 1'b0;
    pop_i  = 1'b0;
    data_i = 8'h00;
    #1;
    check_state("rst", 0, 1'b0, 1'b1);
    check_eq("rst.ovf", 32'(overflow_o),  32'd0);
    check_eq("rst.unf", 32'(underflow_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    check_state("post_rst", 0, 1'b0, 1'b1);

    // Fill and drain in order
    cyc(1'b1, 8'h11, 1'b0);
    check_state("p1", 1, 1'b0, 1'b1);
    check_eq("p1.head", 32'(data_o), 32'h11);
    cyc(1'b1, 8'h22, 1'b0);
    check_state("p2", 2, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    check_state("p3", 3, 1'b1, 1'b0);
    cyc(1'b1, 8'h44, 1'b0);
    check_state("p4", 4, 1'b1, 1'b0);
    pop_expect("d1", 8'h11);
    check_state("d1", 3, 1'b1, 1'b0);
    pop_expect("d2", 8'h22);
    pop_expect("d3", 8'h33);
    check_state("d3", 1, 1'b0, 1'b1);
    pop_expect("d4", 8'h44);
    check_state("d4", 0, 1'b0, 1'b1);

    // Overflow: push on full without pop is dropped
    fill4();
    cyc(1'b1, 8'h55, 1'b0);
    check_eq("ovf.pulse", 32'(overflow_o), 32'd1);
    check_state("ovf", 4, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check_eq("ovf.clear", 32'(overflow_o), 32'd0);
    pop_expect("ovf_d1", 8'h11);
    pop_expect("ovf_d2", 8'h22);
    pop_expect("ovf_d3", 8'h33);
    pop_expect("ovf_d4", 8'h44);
    check_state("ovf_end", 0, 1'b0, 1'b1);

    // Push with pop on full is accepted
    fill4();
    cyc(1'b1, 8'h55, 1'b1);
    check_eq("fpp.ovf", 32'(overflow_o), 32'd0);
    check_state("fpp", 4, 1'b1, 1'b0);
    pop_expect("fpp_d1", 8'h22);
    pop_expect("fpp_d2", 8'h33);
    pop_expect("fpp_d3", 8'h44);
    pop_expect("fpp_d4", 8'h55);
    check_state("fpp_end", 0, 1'b0, 1'b1);

    // Push with pop on empty: push taken, pop rejected
    cyc(1'b1, 8'hAA, 1'b1);
    check_eq("epp.unf", 32'(underflow_o), 32'd1);
    check_state("epp", 1, 1'b0, 1'b1);
    check_eq("epp.head", 32'(data_o), 32'hAA);
    cyc(1'b0, 8'h00, 1'b0);
    check_eq("epp.unf_clear", 32'(underflow_o), 32'd0);
    pop_expect("epp_d", 8'hAA);
    check_state("epp_end", 0, 1'b0, 1'b1);

    // Steady push/pop pairs across pointer wrap
    q = {};
    cyc(1'b1, 8'h01, 1'b0); q.push_back(8'h01);
    cyc(1'b1, 8'h02, 1'b0); q.push_back(8'h02);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'h60 + 8'(i);
      check_eq($sformatf("wrap%0d.head", i), 32'(data_o), 32'(q[0]));
      cyc(1'b1, d, 1'b1);
      void'(q.pop_front());
      q.push_back(d);
      check_eq($sformatf("wrap%0d.cnt", i), 32'(count_o), 32'd2);
    end
    pop_expect("wrap_d1", 8'h68);
    pop_expect("wrap_d2", 8'h69);
    check_state("wrap_end", 0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with entries present
    cyc(1'b1, 8'hA1, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0);
    check_state("pre_arst", 3, 1'b1, 1'b0);
    #2;
    rst_i = 1'b0;
    #1;
    check_state("arst", 0, 1'b0, 1'b1);
    #3;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_state("arst_rel", 0, 1'b0, 1'b1);

    // Synchronous clear ignores a concurrent push
    cyc(1'b1, 8'hB1, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0);
    check_state("pre_clr", 3, 1'b1, 1'b0);
    clr_i = 1'b1;
    cyc(1'b1, 8'hEE, 1'b0);
    clr_i = 1'b0;
    check_state("clr", 0, 1'b0, 1'b1);
    cyc(1'b1, 8'h77, 1'b0);
    check_state("post_clr", 1, 1'b0, 1'b1);
    check_eq("post_clr.head", 32'(data_o), 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
